// File: rtl/slot_arbiter_pkg.sv
// slot_arbiter_pkg: shared sizes, requester IDs, FSM states and the grant
// payload used by the object-slot arbiter.
package slot_arbiter_pkg;

  localparam int unsigned NREQ  = 3;                  // spawner requesters
  localparam int unsigned NSLOT = 7;                  // gameplay slots (datacount - 1)
  localparam int unsigned SW    = 3;                  // slot index width, 2**SW >= NSLOT
  localparam int unsigned PW    = $clog2(NREQ);       // requester index width
  localparam int unsigned CW    = $clog2(NSLOT + 1);  // clear counter width
  localparam int unsigned SPAN  = 1 << SW;            // index space covered by SW bits

  localparam int unsigned REQ_ENEMY = 0;
  localparam int unsigned REQ_BIRD  = 1;
  localparam int unsigned REQ_CLOUD = 2;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   slot;
  } grant_t;

endpackage

// File: rtl/slot_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req  - eligible request vector
//   ptr  - last granted index; search starts at ptr+1
//   gnt  - one-hot winner (zero when no request)
//   win  - encoded winner index
module rr_arbiter
  import slot_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   win
);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int unsigned idx;
    gnt = '0;
    win = '0;
    idx = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      idx = (32'(ptr) + k) % NREQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        win      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/slot_arbiter.sv
// slot_arbiter: hands out free object-table slots to spawners, one grant per
// clk3 cycle, round-robin among requesters; clears the table after reset.
//   clk3, reset (async, active-low), pause - hold arbitration
//   req/gnt/gnt_slot        - request level / one-cycle grant and its slot
//   free_valid/free_slot    - slot release from despawn logic
//   clr_valid/clr_slot      - post-reset table clear strobes
//   ready, occ, full, err   - status; err is sticky on an illegal release
module slot_arbiter
  import slot_arbiter_pkg::*;
(
  input  logic             clk3,
  input  logic             reset,
  input  logic             pause,
  input  logic [NREQ-1:0]  req,
  input  logic             free_valid,
  input  logic [SW-1:0]    free_slot,
  output logic [NREQ-1:0]  gnt,
  output logic [SW-1:0]    gnt_slot,
  output logic             clr_valid,
  output logic [SW-1:0]    clr_slot,
  output logic             ready,
  output logic [NSLOT-1:0] occ,
  output logic             full,
  output logic             err
);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  grant_t           grant_q, grant_d;
  logic             clr_valid_q, clr_valid_d;
  logic [SW-1:0]    clr_slot_q, clr_slot_d;
  logic             ready_q, ready_d;
  logic [NSLOT-1:0] occ_q, occ_d;
  logic             full_q, full_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  elig, rr_gnt;
  logic [PW-1:0]    rr_win;
  logic [NSLOT-1:0] set_mask, free_mask;
  logic [SW-1:0]    slot_sel;
  logic             slot_free;
  logic [SPAN-1:0]  occ_ext;
  logic             free_legal;
  logic             grant_ok;

  // Last cycle's winner sits out one cycle so it can drop req.
  assign elig = req & ~grant_q.gnt;

  rr_arbiter u_rr (
    .req (elig),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .win (rr_win)
  );

  // Lowest-index free slot; reverse scan leaves the lowest hit in place.
  always_comb begin
    set_mask  = '0;
    slot_sel  = '0;
    slot_free = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        set_mask    = '0;
        set_mask[i] = 1'b1;
        slot_sel    = SW'(i);
        slot_free   = 1'b1;
      end
    end
  end

  // Zero-extend occ so any free_slot value indexes a defined bit.
  assign occ_ext    = SPAN'(occ_q);
  assign free_legal = ({1'b0, free_slot} < (SW + 1)'(NSLOT)) && occ_ext[free_slot];
  assign free_mask  = NSLOT'(1) << free_slot;

  // The edge that leaves HOLD with pause low already arbitrates.
  assign grant_ok = (state_q != ST_INIT) && !pause && slot_free && (|rr_gnt);

  // Next-state, clear sequencing, grant and occupancy update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    grant_d     = '0;
    clr_valid_d = 1'b0;
    clr_slot_d  = '0;
    occ_d       = occ_q;
    err_d       = err_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == CW'(NSLOT)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          clr_valid_d = 1'b1;
          clr_slot_d  = SW'(cnt_q);
          cnt_d       = cnt_q + CW'(1);
        end
      end
      ST_RUN:  if (pause)  state_d = ST_HOLD;
      ST_HOLD: if (!pause) state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase

    // Grant picks from pre-edge occ, so a slot freed now is not reused now.
    if (grant_ok) begin
      grant_d.gnt  = rr_gnt;
      grant_d.slot = slot_sel;
      ptr_d        = rr_win;
      occ_d        = occ_d | set_mask;
    end

    if (free_valid && (state_q != ST_INIT)) begin
      if (free_legal) occ_d = occ_d & ~free_mask;
      else            err_d = 1'b1;
    end

    ready_d = (state_d != ST_INIT);
    full_d  = &occ_d;
  end

  // State and output registers.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= PW'(NREQ - 1);
      grant_q     <= '0;
      clr_valid_q <= 1'b0;
      clr_slot_q  <= '0;
      ready_q     <= 1'b0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      clr_valid_q <= clr_valid_d;
      clr_slot_q  <= clr_slot_d;
      ready_q     <= ready_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign gnt       = grant_q.gnt;
  assign gnt_slot  = grant_q.slot;
  assign clr_valid = clr_valid_q;
  assign clr_slot  = clr_slot_q;
  assign ready     = ready_q;
  assign occ       = occ_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_slot_arbiter.sv
// tb_slot_arbiter: scenario tasks for slot_arbiter with a behavioural model
// that queues the expected post-edge outputs for every driven cycle.
module tb_slot_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned NS = 7;

  logic          clk3;
  logic          reset;
  logic          pause;
  logic [NR-1:0] req;
  logic          free_valid;
  logic [2:0]    free_slot;
  logic [NR-1:0] gnt;
  logic [2:0]    gnt_slot;
  logic          clr_valid;
  logic [2:0]    clr_slot;
  logic          ready;
  logic [NS-1:0] occ;
  logic          full;
  logic          err;

  slot_arbiter dut (
    .clk3       (clk3),
    .reset      (reset),
    .pause      (pause),
    .req        (req),
    .free_valid (free_valid),
    .free_slot  (free_slot),
    .gnt        (gnt),
    .gnt_slot   (gnt_slot),
    .clr_valid  (clr_valid),
    .clr_slot   (clr_slot),
    .ready      (ready),
    .occ        (occ),
    .full       (full),
    .err        (err)
  );

  initial begin
    clk3 = 1'b0;
    forever #5 clk3 = ~clk3;
  end

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [2:0]    slot;
    logic [NS-1:0] occ;
    logic          full;
    logic          err;
  } obs_t;

  obs_t sb[$];
  obs_t got, exp_o;
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: 0 = clearing, 1 = running, 2 = held.
  logic [NS-1:0] m_occ;
  logic [NR-1:0] m_gnt;
  int            m_ptr;
  logic          m_err;
  int            m_state;

  task automatic model_reset();
    m_occ = '0; m_gnt = '0; m_ptr = NR - 1; m_err = 1'b0; m_state = 0;
    sb.delete();
  endtask

  // Predict the outputs after the coming edge from the inputs now driven.
  task automatic predict();
    logic [NR-1:0] elig, g;
    logic [2:0]    s;
    logic [NS-1:0] nocc;
    int            win;
    elig = req & ~m_gnt; g = '0; s = '0; nocc = m_occ; win = 0;
    if (m_state != 0 && !pause && m_occ != {NS{1'b1}}) begin
      for (int k = 1; k <= NR; k++)
        if (g == '0 && elig[(m_ptr + k) % NR]) begin
          win = (m_ptr + k) % NR;
          g[win] = 1'b1;
        end
      if (g != '0) begin
        for (int i = NS - 1; i >= 0; i--) if (!m_occ[i]) s = 3'(i);
        nocc[s] = 1'b1;
        m_ptr   = win;
      end
    end
    if (m_state != 0 && free_valid) begin
      if (free_slot >= 3'(NS) || !m_occ[free_slot]) m_err = 1'b1;
      else nocc[free_slot] = 1'b0;
    end
    if (m_state == 1 && pause) m_state = 2;
    else if (m_state == 2 && !pause) m_state = 1;
    m_gnt = g;
    m_occ = nocc;
    sb.push_back({g, s, nocc, &nocc, m_err});
  endtask

  task automatic tick();
    predict();
    @(posedge clk3);
    #1;
    got = {gnt, (gnt == '0) ? 3'b000 : gnt_slot, occ, full, err};
    exp_o = sb.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b0; pause = 1'b0; req = '0; free_valid = 1'b0; free_slot = '0;
    model_reset();
    repeat (2) @(posedge clk3);
    #1;
    n_checks++;
    if ({gnt, gnt_slot, clr_valid, clr_slot, ready, occ, full, err} !== '0) begin
      n_errors++;
      $display("FAIL reset_values: got gnt=%b slot=%0d clr=%b/%0d ready=%b occ=%b full=%b err=%b, want all 0",
               gnt, gnt_slot, clr_valid, clr_slot, ready, occ, full, err);
    end
    @(negedge clk3);
    reset = 1'b1;
  endtask

  task automatic test_init_sequence();
    for (int e = 1; e <= NS; e++) begin
      @(posedge clk3);
      #1;
      n_checks++;
      if ({clr_valid, clr_slot, ready} !== {1'b1, 3'(e - 1), 1'b0}) begin
        n_errors++;
        $display("FAIL init_clear edge%0d: got clr_valid=%b clr_slot=%0d ready=%b, want 1 %0d 0",
                 e, clr_valid, clr_slot, ready, e - 1);
      end
    end
    @(posedge clk3);
    #1;
    n_checks++;
    if ({clr_valid, ready, occ, gnt} !== {1'b0, 1'b1, 7'b0, 3'b0}) begin
      n_errors++;
      $display("FAIL init_done: got clr_valid=%b ready=%b occ=%b gnt=%b, want 0 1 0 0",
               clr_valid, ready, occ, gnt);
    end
    m_state = 1;
  endtask

  task automatic test_round_robin_fill();
    req = 3'b111;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL rr_fill cyc%0d: got %b want %b", c, got, exp_o);
      end
      n_checks++;
      if (c < NS) begin
        if ({gnt, gnt_slot} !== {3'(1 << (c % 3)), 3'(c)}) begin
          n_errors++;
          $display("FAIL rr_order cyc%0d: got gnt=%b slot=%0d want gnt=%b slot=%0d",
                   c, gnt, gnt_slot, 3'(1 << (c % 3)), c);
        end
      end else if ({gnt, full} !== {3'b000, 1'b1}) begin
        n_errors++;
        $display("FAIL rr_full cyc%0d: got gnt=%b full=%b want 000 1", c, gnt, full);
      end
    end
    req = '0;
  endtask

  task automatic test_free_regrant();
    // Free slot 4 on a full table with req[1] pending, then regrant it.
    req = 3'b010; free_valid = 1'b1; free_slot = 3'd4;
    tick();
    n_checks++;
    if (got !== exp_o || gnt !== 3'b000 || occ !== 7'b1101111) begin
      n_errors++;
      $display("FAIL free_full: got %b want %b (gnt 000 occ 1101111)", got, exp_o);
    end
    free_valid = 1'b0;
    tick();
    n_checks++;
    if (got !== exp_o || gnt !== 3'b010 || gnt_slot !== 3'd4 || full !== 1'b1) begin
      n_errors++;
      $display("FAIL regrant: got %b want %b (gnt 010 slot 4 full)", got, exp_o);
    end
    req = '0;
    tick();
    n_checks++;
    if (got !== exp_o) begin
      n_errors++;
      $display("FAIL regrant_idle: got %b want %b", got, exp_o);
    end
    // Back to back: slot 0 freed, then grant+free in one cycle.
    free_valid = 1'b1; free_slot = 3'd0;
    tick();
    free_slot = 3'd1; req = 3'b001;
    tick();
    n_checks++;
    if (got !== exp_o || gnt !== 3'b001 || gnt_slot !== 3'd0 || occ !== 7'b1111101) begin
      n_errors++;
      $display("FAIL same_cycle: got %b want %b (gnt 001 slot 0 occ 1111101)", got, exp_o);
    end
    free_valid = 1'b0; req = 3'b100;
    tick();
    n_checks++;
    if (got !== exp_o || gnt !== 3'b100 || gnt_slot !== 3'd1) begin
      n_errors++;
      $display("FAIL back_to_back: got %b want %b (gnt 100 slot 1)", got, exp_o);
    end
    req = '0;
    tick();
  endtask

  task automatic test_illegal_free();
    free_valid = 1'b1; free_slot = 3'd5;
    tick();
    n_checks++;
    if (got !== exp_o || err !== 1'b0) begin
      n_errors++;
      $display("FAIL legal_free: got %b want %b", got, exp_o);
    end
    tick();
    n_checks++;
    if (got !== exp_o || err !== 1'b1 || occ !== 7'b1011111) begin
      n_errors++;
      $display("FAIL double_free: got %b want %b (err 1 occ 1011111)", got, exp_o);
    end
    free_slot = 3'd7;
    tick();
    n_checks++;
    if (got !== exp_o || occ !== 7'b1011111) begin
      n_errors++;
      $display("FAIL range_free: got %b want %b", got, exp_o);
    end
    free_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL err_sticky: got err=%b want 1", err);
    end
  endtask

  task automatic test_pause();
    pause = 1'b1; req = 3'b001;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (got !== exp_o || gnt !== 3'b000) begin
        n_errors++;
        $display("FAIL pause_hold cyc%0d: got %b want %b", c, got, exp_o);
      end
    end
    pause = 1'b0;
    tick();
    n_checks++;
    if (got !== exp_o || gnt !== 3'b001 || gnt_slot !== 3'd5) begin
      n_errors++;
      $display("FAIL pause_release: got %b want %b (gnt 001 slot 5)", got, exp_o);
    end
    req = '0;
    tick();
    n_checks++;
    if (got !== exp_o || gnt !== 3'b000) begin
      n_errors++;
      $display("FAIL pulse_width: got %b want %b", got, exp_o);
    end
  endtask

  task automatic test_reset_mid_init();
    @(negedge clk3);
    reset = 1'b0;
    model_reset();
    @(negedge clk3);
    reset = 1'b1;
    repeat (3) @(posedge clk3);
    #1;
    n_checks++;
    if ({clr_valid, clr_slot} !== {1'b1, 3'd2}) begin
      n_errors++;
      $display("FAIL mid_init_pre: got clr_valid=%b clr_slot=%0d want 1 2", clr_valid, clr_slot);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({gnt, gnt_slot, clr_valid, clr_slot, ready, occ, full, err} !== '0) begin
      n_errors++;
      $display("FAIL mid_init_reset: got clr=%b/%0d ready=%b occ=%b err=%b, want all 0",
               clr_valid, clr_slot, ready, occ, err);
    end
    @(negedge clk3);
    reset = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk3);
      #1;
      n_checks++;
      if ({clr_valid, clr_slot, ready} !== {1'b1, 3'(e - 1), 1'b0}) begin
        n_errors++;
        $display("FAIL init_restart edge%0d: got clr_valid=%b clr_slot=%0d ready=%b",
                 e, clr_valid, clr_slot, ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_round_robin_fill();
    test_free_regrant();
    test_illegal_free();
    test_pause();
    test_reset_mid_init();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
